// File: rtl/alu_issue_stage_if.sv
// Issue-to-EX bundle interface: instruction/operand inputs, ALU bundle outputs and flush.
// The stage uses the slave modport; the driving environment uses master.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AOPW = 6
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [AOPW-1:0] aluop;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;

    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, op1, op2, aluop, rd, rd_we, illegal
    );

    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, op1, op2, aluop, rd, rd_we, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into an ALU bundle, registered through a 2-entry skid buffer.
// Define ALU_ISSUE_SHAMT_MASK_EN to mask register shift amounts for OP SLL/SRL/SRA to 5 bits.
module alu_issue_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AOPW = 6
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave stage_io
);

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [AOPW-1:0] aluop;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    localparam logic [AOPW-1:0] AluAdd  = AOPW'(0);
    localparam logic [AOPW-1:0] AluSll  = AOPW'(1);
    localparam logic [AOPW-1:0] AluSlt  = AOPW'(2);
    localparam logic [AOPW-1:0] AluSltu = AOPW'(3);
    localparam logic [AOPW-1:0] AluXor  = AOPW'(4);
    localparam logic [AOPW-1:0] AluSrl  = AOPW'(5);
    localparam logic [AOPW-1:0] AluOr   = AOPW'(6);
    localparam logic [AOPW-1:0] AluAnd  = AOPW'(7);
    localparam logic [AOPW-1:0] AluSra  = AOPW'(8);
    localparam logic [AOPW-1:0] AluSub  = AOPW'(9);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;
    localparam logic [6:0] F7Alt    = 7'b0100000;

    function automatic logic [AOPW-1:0] f3_aluop(input logic [2:0] f3);
        logic [AOPW-1:0] op;
        unique case (f3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd_f;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_shift;

    assign opcode   = stage_io.instr[6:0];
    assign rd_f     = stage_io.instr[11:7];
    assign f3       = stage_io.instr[14:12];
    assign f7       = stage_io.instr[31:25];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    bundle_t dec;
    logic    dec_legal;

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        dec.rd    = rd_f;
        case (opcode)
            OpcOp: begin
                dec.op1   = stage_io.rs1_data;
                dec.op2   = stage_io.rs2_data;
                dec.aluop = f3_aluop(f3);
                if (f7 == 7'b0) begin
                    dec_legal = 1'b1;
                end else if (f7 == F7Alt && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec_legal = 1'b1;
                    dec.aluop = (f3 == 3'b000) ? AluSub : AluSra;
                end
`ifdef ALU_ISSUE_SHAMT_MASK_EN
                if (is_shift) begin
                    dec.op2 = XLEN'(stage_io.rs2_data[4:0]);
                end
`endif
            end
            OpcOpImm: begin
                dec.op1   = stage_io.rs1_data;
                dec.op2   = XLEN'($signed(stage_io.instr[31:20]));
                dec.aluop = f3_aluop(f3);
                dec_legal = 1'b1;
                if (is_shift) begin
                    // imm[11:5] selects SRLI/SRAI; anything else in those bits is reserved
                    dec.op2   = XLEN'(stage_io.instr[24:20]);
                    dec_legal = (f7 == 7'b0) || (f3 == 3'b101 && f7 == F7Alt);
                    if (f3 == 3'b101 && f7 == F7Alt) begin
                        dec.aluop = AluSra;
                    end
                end
            end
            OpcLui: begin
                dec.op2   = XLEN'($signed({stage_io.instr[31:12], 12'b0}));
                dec.aluop = AluAdd;
                dec_legal = 1'b1;
            end
            OpcAuipc: begin
                dec.op1   = stage_io.pc;
                dec.op2   = XLEN'($signed({stage_io.instr[31:12], 12'b0}));
                dec.aluop = AluAdd;
                dec_legal = 1'b1;
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec.op1     = '0;
            dec.op2     = '0;
            dec.aluop   = '0;
            dec.illegal = 1'b1;
        end
        dec.rd_we = dec_legal && (rd_f != 5'd0);
    end

    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    logic    out_valid_q, out_valid_d;
    logic    skid_valid_q, skid_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept;
    logic    stalled;

    assign accept  = stage_io.in_valid && in_ready_q;
    assign stalled = out_valid_q && !stage_io.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (stage_io.flush) begin
            // Valids only; stale data in the registers is harmless once invalid
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (stalled) begin
            if (accept) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else begin
            out_valid_d = 1'b0;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign stage_io.in_ready  = in_ready_q;
    assign stage_io.out_valid = out_valid_q;
    assign stage_io.op1       = out_q.op1;
    assign stage_io.op2       = out_q.op2;
    assign stage_io.aluop     = out_q.aluop;
    assign stage_io.rd        = out_q.rd;
    assign stage_io.rd_we     = out_q.rd_we;
    assign stage_io.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid backpressure, flush and async reset.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    alu_issue_stage_if #(.XLEN(32), .AOPW(6)) bus ();

    alu_issue_stage #(.XLEN(32), .AOPW(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stage_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one edge, then sample the registered result.
    task automatic issue(input logic [31:0] ins, input logic [31:0] pc_v,
                         input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc       = pc_v;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] e_op1,
                                input logic [31:0] e_op2, input logic [5:0] e_aluop,
                                input logic [4:0] e_rd, input logic e_we, input logic e_ill);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".op1"}, bus.op1, e_op1);
        check({tag, ".op2"}, bus.op2, e_op2);
        check({tag, ".aluop"}, 32'(bus.aluop), 32'(e_aluop));
        check({tag, ".rd"}, 32'(bus.rd), 32'(e_rd));
        check({tag, ".rd_we"}, 32'(bus.rd_we), 32'(e_we));
        check({tag, ".illegal"}, 32'(bus.illegal), 32'(e_ill));
    endtask

    logic [31:0] sll_op2;

    initial begin
`ifdef ALU_ISSUE_SHAMT_MASK_EN
        sll_op2 = 32'h5;
`else
        sll_op2 = 32'h25;
`endif
        rst_n         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.pc        = 32'h0;
        bus.rs1_data  = 32'h0;
        bus.rs2_data  = 32'h0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.op1", bus.op1, 32'd0);
        check("rst.op2", bus.op2, 32'd0);
        check("rst.aluop", 32'(bus.aluop), 32'd0);
        check("rst.rd", 32'(bus.rd), 32'd0);
        check("rst.rd_we", 32'(bus.rd_we), 32'd0);
        check("rst.illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode vectors with EX always ready
        issue(32'h00500093, 32'h0, 32'h0, 32'h0);
        check_bundle("addi", 32'h0, 32'h5, 6'd0, 5'd1, 1'b1, 1'b0);
        issue(32'h402081B3, 32'h0, 32'd10, 32'd3);
        check_bundle("sub", 32'd10, 32'd3, 6'd9, 5'd3, 1'b1, 1'b0);
        issue(32'h40335293, 32'h0, 32'h80000000, 32'h0);
        check_bundle("srai", 32'h80000000, 32'h3, 6'd8, 5'd5, 1'b1, 1'b0);
        issue(32'h123453B7, 32'h0, 32'hDEADBEEF, 32'h0);
        check_bundle("lui", 32'h0, 32'h12345000, 6'd0, 5'd7, 1'b1, 1'b0);
        issue(32'h00001097, 32'h100, 32'h0, 32'h0);
        check_bundle("auipc", 32'h100, 32'h1000, 6'd0, 5'd1, 1'b1, 1'b0);
        issue(32'h022081B3, 32'h0, 32'd7, 32'd9);
        check_bundle("mul", 32'h0, 32'h0, 6'd0, 5'd3, 1'b0, 1'b1);
        issue(32'h002091B3, 32'h0, 32'h1, 32'h25);
        check_bundle("sll", 32'h1, sll_op2, 6'd1, 5'd3, 1'b1, 1'b0);
        issue(32'hFFF00013, 32'h0, 32'h4, 32'h0);
        check_bundle("addi_x0", 32'h4, 32'hFFFFFFFF, 6'd0, 5'd0, 1'b0, 1'b0);
        issue(32'h40109093, 32'h0, 32'h4, 32'h0);
        check_bundle("slli_bad", 32'h0, 32'h0, 6'd0, 5'd1, 1'b0, 1'b1);
        issue(32'h4020F1B3, 32'h0, 32'h4, 32'h5);
        check_bundle("and_alt", 32'h0, 32'h0, 6'd0, 5'd3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("idle.out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: A at output, B in skid, C held at input
        bus.out_ready = 1'b0;
        issue(32'h00100093, 32'h0, 32'h0, 32'h0);
        check("bp.a.in_ready", 32'(bus.in_ready), 32'd1);
        check("bp.a.op2", bus.op2, 32'd1);
        issue(32'h00200113, 32'h0, 32'h0, 32'h0);
        check("bp.b.in_ready", 32'(bus.in_ready), 32'd0);
        check("bp.b.hold_op2", bus.op2, 32'd1);
        check("bp.b.out_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00300193;
        @(posedge clk);
        #1;
        check("bp.c.hold_op2", bus.op2, 32'd1);
        check("bp.c.hold_rd", 32'(bus.rd), 32'd1);
        check("bp.c.in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.rel.b_op2", bus.op2, 32'd2);
        check("bp.rel.b_rd", 32'(bus.rd), 32'd2);
        check("bp.rel.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp.rel.c_op2", bus.op2, 32'd3);
        check("bp.rel.c_rd", 32'(bus.rd), 32'd3);
        check("bp.rel.c_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        check("bp.drain.out_valid", 32'(bus.out_valid), 32'd0);

        // Flush with output and skid full and a new instruction offered
        bus.out_ready = 1'b0;
        issue(32'h00100093, 32'h0, 32'h0, 32'h0);
        issue(32'h00200113, 32'h0, 32'h0, 32'h0);
        check("fl.full.in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00400213;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl.out_valid", 32'(bus.out_valid), 32'd0);
        check("fl.in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fl.no_stale", 32'(bus.out_valid), 32'd0);

        // Flush on an empty stage drops an instruction the stage could accept
        @(negedge clk);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr    = 32'h00500293;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("fl2.out_valid", 32'(bus.out_valid), 32'd0);
        check("fl2.in_ready", 32'(bus.in_ready), 32'd1);

        // Async reset with both entries full
        bus.out_ready = 1'b0;
        issue(32'h00100093, 32'h0, 32'h0, 32'h0);
        issue(32'h00200113, 32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.in_ready", 32'(bus.in_ready), 32'd1);
        check("arst.op2", bus.op2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst.after.out_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
